act_stream_loader: RTL

- Upstream feeder for the RTLinf accelerator's local (host-side) activation write port.
- Accepts a valid/ready stream of activation groups and claims the target activation memory (assign on read/write port NUM_KERNELS).
- Writes the words to consecutive addresses, releases the memory (unassign), then pulses done.
- Replaces the hand-sequenced assign/write/unassign fill procedure with one FSM.

---
 rtl/rtlinf_pkg.sv | 23 ++
 rtl/act_stream_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rtlinf_pkg.sv
// Shared RTLinf definitions: activation-loader state encoding plus port and word-width helpers.
package rtlinf_pkg;

    localparam int unsigned LOADER_STATE_W = 3;

    localparam logic [LOADER_STATE_W-1:0] LD_IDLE     = 3'd0;
    localparam logic [LOADER_STATE_W-1:0] LD_ASSIGN   = 3'd1;
    localparam logic [LOADER_STATE_W-1:0] LD_STREAM   = 3'd2;
    localparam logic [LOADER_STATE_W-1:0] LD_FLUSH    = 3'd3;
    localparam logic [LOADER_STATE_W-1:0] LD_UNASSIGN = 3'd4;
    localparam logic [LOADER_STATE_W-1:0] LD_DONE     = 3'd5;

    // The host-side (local) port sits just past the kernel ports.
    function automatic int unsigned local_port(input int unsigned num_kernels);
        return num_kernels;
    endfunction

    function automatic int unsigned word_width(input int unsigned group_size,
                                               input int unsigned data_width);
        return group_size * data_width;
    endfunction

endpackage

// File: rtl/act_stream_loader.sv
// Host-side activation loader: assigns an RTLinf activation memory, streams words into
// consecutive addresses, unassigns the memory and pulses done.
module act_stream_loader
    import rtlinf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned GROUP_SIZE           = 4,
    parameter int unsigned NUM_KERNELS          = 1,
    parameter int unsigned LOG_NUM_KERNELS      = 1,
    parameter int unsigned LOG_NUM_ACT_MEMORIES = 1,
    parameter int unsigned LOG_MAX_ADDRESS      = 12
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [LOG_NUM_ACT_MEMORIES-1:0]                   start_memory,
    input  logic [LOG_MAX_ADDRESS-1:0]                        start_base_addr,
    input  logic [LOG_MAX_ADDRESS:0]                          start_num_words,
    input  logic [word_width(GROUP_SIZE, DATA_WIDTH)-1:0]     in_data,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    output logic                                              cmd_act_assign,
    output logic                                              cmd_act_unassign,
    output logic [LOG_NUM_KERNELS:0]                          cmd_act_read_port,
    output logic [LOG_NUM_KERNELS:0]                          cmd_act_write_port,
    output logic [LOG_NUM_ACT_MEMORIES-1:0]                   cmd_act_memory,
    output logic                                              act_write,
    output logic [LOG_MAX_ADDRESS-1:0]                        act_write_addr,
    output logic [word_width(GROUP_SIZE, DATA_WIDTH)-1:0]     act_write_data,
    output logic                                              busy,
    output logic                                              done
);

    localparam int unsigned WORD_W = word_width(GROUP_SIZE, DATA_WIDTH);
    localparam logic [LOG_NUM_KERNELS:0] LOCAL_PORT =
        (LOG_NUM_KERNELS+1)'(local_port(NUM_KERNELS));
    localparam logic [LOG_MAX_ADDRESS:0] CNT_ONE = (LOG_MAX_ADDRESS+1)'(1);

    logic [LOADER_STATE_W-1:0]       state_q, state_d;
    logic [LOG_MAX_ADDRESS:0]        count_q, count_d;
    logic [LOG_MAX_ADDRESS:0]        num_q;
    logic [LOG_MAX_ADDRESS-1:0]      base_q;
    logic [LOG_NUM_ACT_MEMORIES-1:0] mem_q;
    logic                            in_ready_q;
    logic                            assign_q;
    logic                            unassign_q;
    logic                            write_q;
    logic [LOG_MAX_ADDRESS-1:0]      addr_q;
    logic [WORD_W-1:0]               data_q;
    logic                            busy_q;
    logic                            done_q;
    logic [LOG_NUM_KERNELS:0]        rport_q;
    logic [LOG_NUM_KERNELS:0]        wport_q;
    logic                            handshake;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        handshake = (state_q == LD_STREAM) && in_valid && in_ready_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d = LD_ASSIGN;
                    count_d = '0;
                end
            end
            LD_ASSIGN:   state_d = (num_q != '0) ? LD_STREAM : LD_UNASSIGN;
            LD_STREAM: begin
                if (handshake) begin
                    count_d = count_q + CNT_ONE;
                    if (count_d == num_q) state_d = LD_FLUSH;
                end
            end
            LD_FLUSH:    state_d = LD_UNASSIGN;
            LD_UNASSIGN: state_d = LD_DONE;
            LD_DONE:     state_d = LD_IDLE;
            default:     state_d = LD_IDLE;
        endcase
    end

    // Every strobe is registered from the next state, so each appears in the cycle the FSM sits there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            count_q    <= '0;
            num_q      <= '0;
            base_q     <= '0;
            mem_q      <= '0;
            in_ready_q <= 1'b0;
            assign_q   <= 1'b0;
            unassign_q <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rport_q    <= LOCAL_PORT;
            wport_q    <= LOCAL_PORT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if ((state_q == LD_IDLE) && start) begin
                mem_q  <= start_memory;
                base_q <= start_base_addr;
                num_q  <= start_num_words;
            end
            busy_q     <= (state_d != LD_IDLE);
            assign_q   <= (state_d == LD_ASSIGN);
            in_ready_q <= (state_d == LD_STREAM);
            unassign_q <= (state_d == LD_UNASSIGN);
            done_q     <= (state_d == LD_DONE);
            write_q    <= handshake;
            if (handshake) begin
                addr_q <= base_q + count_q[LOG_MAX_ADDRESS-1:0];
                data_q <= in_data;
            end
            rport_q <= LOCAL_PORT;
            wport_q <= LOCAL_PORT;
        end
    end

    assign in_ready           = in_ready_q;
    assign cmd_act_assign     = assign_q;
    assign cmd_act_unassign   = unassign_q;
    assign cmd_act_read_port  = rport_q;
    assign cmd_act_write_port = wport_q;
    assign cmd_act_memory     = mem_q;
    assign act_write          = write_q;
    assign act_write_addr     = addr_q;
    assign act_write_data     = data_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
